// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
// Registered, handshaked ALU. Single-cycle ops (add/sub/logic/shift/move/
// compare) reach the output register one cycle after they are accepted. MUL
// runs a WIDTH-cycle shift-and-add in a two-state FSM and holds off upstream
// (busy, in_ready low) until its result is in the output register.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (accept = in_valid && in_ready)
//   op, A, B            operation code and operands (B[SHW-1:0] = shift)
//   out_valid/out_ready result handshake
//   Out, N, Z, V, C     registered result and its flags
//   illegal             registered: result came from an undefined op code
//   busy                multiply in progress
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             C,
    output logic             illegal,
    output logic             busy
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_MOVA = 4'd6;
    localparam logic [3:0] OP_MOVB = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_ASR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_CMP  = 4'd11;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d;
    logic               ill_q, ill_d;

    logic               accept;

    // Single-cycle datapath
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH:0]     shl_full;
    logic [WIDTH:0]     shr_full;
    logic signed [WIDTH:0] asr_full;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_n, alu_z, alu_v, alu_c, alu_ill;

    // Multiplier step
    logic [2*WIDTH-1:0] acc_next;
    logic               mul_done;

    assign sh = B[SHW-1:0];

    // Shifts are done one bit wider so the last bit shifted out lands in the
    // extra position and becomes C; a zero shift leaves a 0 there.
    always_comb begin
        add_full = {1'b0, A} + {1'b0, B};
        sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        shl_full = {1'b0, A} << sh;
        shr_full = {A, 1'b0} >> sh;
        asr_full = $signed({A, 1'b0}) >>> sh;
    end

    always_comb begin
        alu_res = A;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = (op == OP_CMP) ? A : sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SHL: begin
                alu_res = shl_full[WIDTH-1:0];
                alu_c   = shl_full[WIDTH];
            end
            OP_MOVA: alu_res = A;
            OP_MOVB: alu_res = B;
            OP_SHR: begin
                alu_res = shr_full[WIDTH:1];
                alu_c   = shr_full[0];
            end
            OP_ASR: begin
                alu_res = asr_full[WIDTH:1];
                alu_c   = asr_full[0];
            end
            OP_MUL:  alu_res = A;  // never loaded from here; the FSM handles MUL
            default: alu_ill = 1'b1;
        endcase
        // CMP keeps A in Out but reports N/Z of the difference
        if (op == OP_CMP) begin
            alu_n = sub_full[WIDTH-1];
            alu_z = (sub_full[WIDTH-1:0] == '0);
        end else begin
            alu_n = alu_res[WIDTH-1];
            alu_z = (alu_res == '0);
        end
    end

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_done = (state_q == S_MUL) && (cnt_q == SHW'(WIDTH - 1));

    assign busy     = (state_q == S_MUL);
    assign in_ready = !busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        n_d         = n_q;
        z_d         = z_q;
        v_d         = v_q;
        c_d         = c_q;
        ill_d       = ill_q;

        // A consumed result drops valid unless something reloads below
        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d  = S_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, A};
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        out_d       = alu_res;
                        n_d         = alu_n;
                        z_d         = alu_z;
                        v_d         = alu_v;
                        c_d         = alu_c;
                        ill_d       = alu_ill;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                // in_ready was required to start, so the output register is
                // free by the time the last iteration completes
                if (mul_done) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_d       = acc_next[WIDTH-1:0];
                    n_d         = acc_next[WIDTH-1];
                    z_d         = (acc_next[WIDTH-1:0] == '0);
                    v_d         = 1'b0;
                    c_d         = |acc_next[2*WIDTH-1:WIDTH];
                    ill_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            v_q         <= 1'b0;
            c_q         <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            n_q         <= n_d;
            z_q         <= z_d;
            v_q         <= v_d;
            c_q         <= c_d;
            ill_q       <= ill_d;
        end
    end

    // Multiplier working registers are only meaningful in S_MUL and are
    // always initialised on entry, so they carry no reset.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
    end

    assign out_valid = out_valid_q;
    assign Out       = out_q;
    assign N         = n_q;
    assign Z         = z_q;
    assign V         = v_q;
    assign C         = c_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
// Directed bench for alu_pipe (WIDTH=16). Expected results are queued when an
// operand set is accepted and compared when the DUT hands the result over.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] out;
        logic         n;
        logic         z;
        logic         v;
        logic         c;
        logic         ill;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Out;
    logic         N, Z, V, C;
    logic         illegal;
    logic         busy;

    int   tests  = 0;
    int   failed = 0;
    res_t sb[$];

    logic [W-1:0] held_val;
    bit           held_pending = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .N         (N),
        .Z         (Z),
        .V         (V),
        .C         (C),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk(input logic [W-1:0] o, input logic n, z, v, c, ill);
        res_t r;
        r.out = o; r.n = n; r.z = z; r.v = v; r.c = c; r.ill = ill;
        return r;
    endfunction

    // Reference model written with 32-bit integer arithmetic
    function automatic res_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t        r;
        logic [31:0] s;
        int          sd;
        int          sh;
        logic [W-1:0] d;
        r  = '0;
        s  = '0;
        sh = int'(b[3:0]);
        d  = '0;
        case (o)
            4'd0: begin
                s  = {16'h0, a} + {16'h0, b};
                r.out = s[15:0]; r.c = s[16];
                sd = int'($signed(a)) + int'($signed(b));
                r.v = (sd > 32767) || (sd < -32768);
            end
            4'd1, 4'd11: begin
                s  = {16'h0, a} + {16'h0, ~b} + 32'd1;
                d  = s[15:0];
                r.out = (o == 4'd11) ? a : d;
                r.c = s[16];
                sd = int'($signed(a)) - int'($signed(b));
                r.v = (sd > 32767) || (sd < -32768);
            end
            4'd2: r.out = a & b;
            4'd3: r.out = a | b;
            4'd4: r.out = a ^ b;
            4'd5: begin
                s = {16'h0, a} << sh;
                r.out = s[15:0];
                r.c = (sh != 0) && s[16];
            end
            4'd6: r.out = a;
            4'd7: r.out = b;
            4'd8: begin
                r.out = a >> sh;
                r.c = (sh != 0) && a[sh-1];
            end
            4'd9: begin
                sd = int'($signed(a)) >>> sh;
                s  = sd;
                r.out = s[15:0];
                r.c = (sh != 0) && a[sh-1];
            end
            4'd10: begin
                s = {16'h0, a} * {16'h0, b};
                r.out = s[15:0];
                r.c = (s[31:16] != 16'h0);
            end
            default: begin
                r.out = a; r.ill = 1'b1;
            end
        endcase
        if (o == 4'd11) begin
            r.n = d[15]; r.z = (d == 16'h0);
        end else begin
            r.n = r.out[15]; r.z = (r.out == 16'h0);
        end
        return r;
    endfunction

    // Result monitor: pops the scoreboard on each handshake and checks that a
    // stalled result does not change.
    always @(negedge clk) begin
        if (!rst_n || !out_valid) begin
            held_pending = 0;
        end else begin
            if (held_pending)
                check("hold_out", 32'(Out), 32'(held_val));
            if (out_ready) begin
                held_pending = 0;
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(Out), 32'hDEAD_BEEF);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    check("result", 32'({Out, N, Z, V, C, illegal}), 32'(e));
                end
            end else begin
                held_val     = Out;
                held_pending = 1;
            end
        end
    end

    // Drive one operand set and hold it until accepted; returns 1 ns after
    // the accepting edge with in_valid dropped.
    task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input res_t e, input bit push);
        int n;
        op = o; A = a; B = b; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready)
            check("accept_timeout", 32'(in_ready), 32'd1);
        else if (push)
            sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic mul_run(input logic [W-1:0] a, input logic [W-1:0] b, input res_t e);
        bit bad;
        send(4'd10, a, b, e, 1);
        bad = 0;
        for (int j = 0; j < W; j++) begin
            @(negedge clk);
            if (!busy || in_ready || out_valid) bad = 1;
        end
        check("mul_stall", 32'(bad), 32'd0);
        @(negedge clk);
        check("mul_latency", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'd0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'({out_valid, Out, N, Z, V, C, illegal, busy}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed single-cycle ops
        send(4'd0,  16'h7FFF, 16'h0001, mk(16'h8000, 1, 0, 1, 0, 0), 1);
        send(4'd1,  16'h0000, 16'h0001, mk(16'hFFFF, 1, 0, 0, 0, 0), 1);
        send(4'd5,  16'h8001, 16'h0001, mk(16'h0002, 0, 0, 0, 1, 0), 1);
        send(4'd9,  16'h8000, 16'h000F, mk(16'hFFFF, 1, 0, 0, 0, 0), 1);
        send(4'd8,  16'hA5C3, 16'h0000, mk(16'hA5C3, 1, 0, 0, 0, 0), 1);
        send(4'd11, 16'h0005, 16'h0007, mk(16'h0005, 1, 0, 0, 0, 0), 1);
        send(4'd13, 16'h1234, 16'h5678, mk(16'h1234, 0, 0, 0, 0, 1), 1);
        send(4'd7,  16'h1234, 16'h0000, mk(16'h0000, 0, 1, 0, 0, 0), 1);

        // Multiplies
        mul_run(16'h0100, 16'h0100, mk(16'h0000, 0, 1, 0, 1, 0));
        mul_run(16'h0003, 16'h0005, mk(16'h000F, 0, 0, 0, 0, 0));

        // Reset during the sixth multiply iteration
        send(4'd10, 16'h1234, 16'h5678, '0, 0);
        repeat (5) @(posedge clk);
        #1;
        check("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_mid_mul", 32'({out_valid, Out, N, Z, V, C, illegal, busy}), 32'd0);
        begin
            bit bad;
            bad = 0;
            for (int j = 0; j < 24; j++) begin
                @(negedge clk);
                if (out_valid || busy) bad = 1;
            end
            check("no_result_after_reset", 32'(bad), 32'd0);
        end
        @(posedge clk);
        #1;

        // Stream of ADDs under toggling backpressure
        begin
            logic [W-1:0] sa [8];
            logic [W-1:0] sbv[8];
            int i;
            int cyc;
            for (int k = 0; k < 8; k++) begin
                sa[k]  = 16'(16'h1111 * (k + 1));
                sbv[k] = 16'(16'h0F0F + k * 16'h2003);
            end
            i = 0;
            cyc = 0;
            while (i < 8 && cyc < 100) begin
                in_valid  = 1'b1;
                op        = 4'd0;
                A         = sa[i];
                B         = sbv[i];
                out_ready = (cyc % 2 == 0);
                @(negedge clk);
                if (in_ready) begin
                    sb.push_back(model(4'd0, sa[i], sbv[i]));
                    i++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            in_valid = 1'b0;
            check("stream_all_accepted", 32'(i), 32'd8);
            for (int k = 0; k < 4; k++) begin
                out_ready = (k % 2 == 0);
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            check("stream_drained", 32'(sb.size()), 32'd0);
        end

        // Mixed single-cycle ops against the model
        begin
            logic [3:0] ops[11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                    4'd6, 4'd7, 4'd8, 4'd9, 4'd11};
            for (int k = 0; k < 12; k++) begin
                logic [3:0]   o;
                logic [W-1:0] a, b;
                o = ops[$urandom_range(0, 10)];
                a = 16'($urandom);
                b = 16'($urandom);
                send(o, a, b, model(o, a, b), 1);
            end
        end
        mul_run(16'hBEEF, 16'h1357, model(4'd10, 16'hBEEF, 16'h1357));

        repeat (4) @(posedge clk);
        #1;
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the datapath's combinational ALU. It registers its result and NZVC flags, extends the operation set with variable-amount shifts, compare and an iterative multiplier, and exposes valid/ready on both sides. It sits between operand read/forwarding and the execute/memory pipeline register, and it can stall upstream while a multiply is in progress.

## Interface
- WIDTH, 16, operand and result width in bits (at least 4, power of two).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  operands and op are valid this cycle.
- in_ready  out  1  block accepts the operands this cycle.
- op  in  4  operation code (see Operation).
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B (for shifts, B[SHW-1:0] is the shift amount).
- out_valid  out  1  Out and flags hold a valid result.
- out_ready  in  1  downstream consumes the result this cycle.
- Out  out  WIDTH  registered result.
- N, Z, V, C  out  1 each  registered flags belonging to Out.
- illegal  out  1  registered; set when the result came from an undefined op.
- busy  out  1  multiply in progress.

## Operation
- Accept when in_valid && in_ready. The rule is in_ready = !busy && (!out_valid || out_ready).
- Op codes:
  - 0 ADD: A+B.
  - 1 SUB: A+~B+1.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL: logical left by B[SHW-1:0].
  - 6 MOVA.
  - 7 MOVB.
  - 8 SHR: logical right.
  - 9 ASR: arithmetic right.
  - 10 MUL: low WIDTH bits of unsigned A*B.
  - 11 CMP: computes A-B for the flags only; Out=A.
  - 12-15: illegal; Out=A, C=V=0, illegal=1.
- Flags:
  - N=Out[WIDTH-1] and Z=(Out==0) for every op. For CMP, N and Z come from the difference, not from Out.
  - ADD/SUB/CMP: C is the carry-out of the WIDTH-bit add (for SUB, C=1 means no borrow, i.e. A>=B unsigned). V is signed overflow.
  - SHL: C=A[WIDTH-sh] when sh!=0, else 0.
  - SHR/ASR: C=A[sh-1] when sh!=0, else 0.
  - MUL: C=1 when the upper WIDTH bits of the full product are nonzero.
  - V=0 for all logic, shift, MOV, MUL and illegal ops.
- A shift amount of 0 passes A unchanged. All arithmetic is modulo 2^WIDTH.
- State machine {IDLE, MUL}:
  - IDLE, accept of op 10: load multiplicand=A, multiplier=B, acc=0, cnt=0, go to MUL, busy=1.
  - IDLE, any other accept: go straight to the output register.
  - MUL, each cycle: if multiplier[0], acc+=multiplicand. Shift the multiplicand left and the multiplier right, and keep a 2·WIDTH-bit partial product for C. cnt++.
  - MUL, when cnt==WIDTH-1 (last iteration): load Out/flags, set out_valid=1, busy=0, go to IDLE.
- Output register:
  - Loads on any single-cycle accept or on multiply completion.
  - out_valid clears on out_ready when no new result loads that cycle.
  - Out and flags are held stable while out_valid && !out_ready.
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, Out=0, N=Z=V=C=0, illegal=0, busy=0, state=IDLE, cnt=0.
  - A multiply in flight is abandoned with no result.

## Timing
- Single-cycle ops: accepted at edge k, out_valid and result visible after edge k+1 (latency 1). Throughput is 1 per cycle when out_ready=1.
- MUL: accepted at edge k, result after edge k+WIDTH. in_ready=0 for cycles k+1..k+WIDTH.
- Back-to-back MULs: the second is accepted at the earliest on the cycle after the first result is valid, and only if out_ready=1 that cycle.
- Simultaneous out_ready and accept: the old result is consumed, the new result loads, and out_valid stays 1.
- Backpressure: out_valid && !out_ready forces in_ready=0. A MUL in progress still completes into the output register only if that register is free. A MUL may start only when in_ready=1, so the register is guaranteed free at completion.
- in_valid with in_ready=0: no state change. The source must hold A, B and op stable.

## Test plan
- Reset mid-MUL, WIDTH=16 (assert rst_n=0 one cycle at iteration 5) -> all outputs 0, busy=0, no out_valid afterwards.
- ADD 0x7FFF+0x0001 -> Out=0x8000, N=1, Z=0, V=1, C=0. SUB 0x0000-0x0001 -> 0xFFFF, C=0, N=1.
- SHL A=0x8001, B=1 -> 0x0002, C=1. ASR A=0x8000, B=15 -> 0xFFFF, C=0. SHR with B=0 -> Out=A, C=0.
- MUL 0x0100·0x0100 -> after 16 cycles Out=0x0000, Z=1, C=1. MUL 3·5 -> 0x000F, C=0. in_ready=0 throughout.
- Stream of 8 ADDs with out_ready toggling 1,0,1,0: every result is delivered exactly once and in order, and Out is held while out_ready=0.
- op=13, A=0x1234 -> Out=0x1234, illegal=1, V=C=0. The next legal op clears illegal.
